// File: rtl/fifo_bank_wr_sched.sv
// Write-side scheduler for the banked audio sample buffer.
// Steers each incoming sample into one FIFO bank, filling banks round-robin,
// never advancing into the bank the reader is draining; unplaceable samples
// are dropped and counted.
// Ports:
//   wr_clk, sys_rst_n   write-domain clock, async active-low reset
//   in_valid, in_data   sample strobe and sample
//   bank_full           per-bank wr_full flags (wr_clk domain)
//   rd_bank_gray        reader's current bank, Gray-coded (rd_clk domain)
//   ovf_clr             clears sticky overflow
//   bank_wr_en          one-hot bank write enable (combinational)
//   bank_wr_data        write data shared by all banks (combinational)
//   wr_bank             current target bank
//   overflow            sticky drop flag
//   drop_cnt            saturating dropped-sample count
//   wrap_cnt            wrapping count of passes from last bank back to bank 0
module fifo_bank_wr_sched #(
    parameter int unsigned NUM_BANK = 5,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DROP_W   = 16,
    parameter int unsigned WRAP_W   = 8
) (
    input  logic                wr_clk,
    input  logic                sys_rst_n,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [NUM_BANK-1:0] bank_full,
    input  logic [2:0]          rd_bank_gray,
    input  logic                ovf_clr,
    output logic [NUM_BANK-1:0] bank_wr_en,
    output logic [DATA_W-1:0]   bank_wr_data,
    output logic [2:0]          wr_bank,
    output logic                overflow,
    output logic [DROP_W-1:0]   drop_cnt,
    output logic [WRAP_W-1:0]   wrap_cnt
);

    localparam int unsigned BANK_W = 3;
    localparam int unsigned PAD_W  = 8;
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANK - 1);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        ADVANCE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [BANK_W-1:0]   rd_sync1;
    logic [BANK_W-1:0]   rd_sync2;
    logic [BANK_W-1:0]   rd_bank_s;
    logic [BANK_W-1:0]   nxt;
    logic [PAD_W-1:0]    full_pad;
    logic [PAD_W-1:0]    en_pad;
    logic                acc;
    logic                drop;
    logic                adv_ok;
    logic                bank_step;

    // Two-flop synchronizer for the reader's Gray-coded bank index
    always_ff @(posedge wr_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_sync1 <= '0;
            rd_sync2 <= '0;
        end else begin
            rd_sync1 <= rd_bank_gray;
            rd_sync2 <= rd_sync1;
        end
    end

    // Gray to binary
    assign rd_bank_s = {rd_sync2[2],
                        rd_sync2[2] ^ rd_sync2[1],
                        rd_sync2[2] ^ rd_sync2[1] ^ rd_sync2[0]};

    // Padding to 8 bits keeps the 3-bit bank index in range for any NUM_BANK
    assign full_pad = PAD_W'(bank_full);
    assign nxt      = (wr_bank == LAST_BANK) ? '0 : wr_bank + BANK_W'(1);
    assign adv_ok   = (nxt != rd_bank_s) && !full_pad[nxt];
    assign acc      = (state == FILL) && in_valid && !full_pad[wr_bank];
    assign drop     = in_valid && !acc;

    // Zero-latency write path: single shift decode of the accept strobe
    assign en_pad       = PAD_W'(acc) << wr_bank;
    assign bank_wr_en   = en_pad[NUM_BANK-1:0];
    assign bank_wr_data = in_data;

    // FSM state register
    always_ff @(posedge wr_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state; bank_step marks a bank switch this cycle
    always_comb begin
        state_nxt = state;
        bank_step = 1'b0;
        case (state)
            FILL: begin
                if (full_pad[wr_bank]) begin
                    state_nxt = ADVANCE;
                end
            end
            ADVANCE: begin
                if (adv_ok) begin
                    bank_step = 1'b1;
                    state_nxt = FILL;
                end else begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (adv_ok) begin
                    bank_step = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // Target bank and wrap counter
    always_ff @(posedge wr_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_bank  <= '0;
            wrap_cnt <= '0;
        end else if (bank_step) begin
            wr_bank <= nxt;
            if (wr_bank == LAST_BANK) begin
                wrap_cnt <= wrap_cnt + WRAP_W'(1);
            end
        end
    end

    // Drop accounting; a drop in the same cycle as ovf_clr keeps overflow set
    always_ff @(posedge wr_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (drop && (drop_cnt != {DROP_W{1'b1}})) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_bank_wr_sched.sv
// Self-checking bench for fifo_bank_wr_sched: a FILL-state vector table plus
// directed sequences for bank switching, hold, wrap, saturation and reset.
// A second instance with a 4-bit drop counter shares all inputs.
module tb_fifo_bank_wr_sched;

    logic        wr_clk = 1'b0;
    logic        sys_rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic [4:0]  bank_full;
    logic [2:0]  rd_bank_gray;
    logic        ovf_clr;

    logic [4:0]  bank_wr_en;
    logic [15:0] bank_wr_data;
    logic [2:0]  wr_bank;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [7:0]  wrap_cnt;

    logic [4:0]  s_bank_wr_en;
    logic [15:0] s_bank_wr_data;
    logic [2:0]  s_wr_bank;
    logic        s_overflow;
    logic [3:0]  s_drop_cnt;
    logic [7:0]  s_wrap_cnt;

    int nchk = 0;
    int nerr = 0;
    int exp_drop = 0;

    typedef struct {
        logic        vld;
        logic [15:0] data;
        logic [4:0]  full;
        logic [4:0]  exp_en;
    } vec_t;

    vec_t vecs[5];

    always #5 wr_clk = ~wr_clk;

    fifo_bank_wr_sched #(.NUM_BANK(5), .DATA_W(16), .DROP_W(16), .WRAP_W(8)) dut (
        .wr_clk(wr_clk), .sys_rst_n(sys_rst_n), .in_valid(in_valid), .in_data(in_data),
        .bank_full(bank_full), .rd_bank_gray(rd_bank_gray), .ovf_clr(ovf_clr),
        .bank_wr_en(bank_wr_en), .bank_wr_data(bank_wr_data), .wr_bank(wr_bank),
        .overflow(overflow), .drop_cnt(drop_cnt), .wrap_cnt(wrap_cnt)
    );

    fifo_bank_wr_sched #(.NUM_BANK(5), .DATA_W(16), .DROP_W(4), .WRAP_W(8)) dut_sat (
        .wr_clk(wr_clk), .sys_rst_n(sys_rst_n), .in_valid(in_valid), .in_data(in_data),
        .bank_full(bank_full), .rd_bank_gray(rd_bank_gray), .ovf_clr(ovf_clr),
        .bank_wr_en(s_bank_wr_en), .bank_wr_data(s_bank_wr_data), .wr_bank(s_wr_bank),
        .overflow(s_overflow), .drop_cnt(s_drop_cnt), .wrap_cnt(s_wrap_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Switch away from bank k: raise its full flag for the FILL and ADVANCE cycles
    task automatic leave_bank(input int k);
        bank_full = 5'(1 << k);
        tick();
        tick();
        bank_full = '0;
    endtask

    initial begin
        vecs[0] = '{vld: 1'b1, data: 16'h1234, full: 5'b00000, exp_en: 5'b00001};
        vecs[1] = '{vld: 1'b0, data: 16'hABCD, full: 5'b00000, exp_en: 5'b00000};
        vecs[2] = '{vld: 1'b1, data: 16'h5555, full: 5'b11110, exp_en: 5'b00001};
        vecs[3] = '{vld: 1'b1, data: 16'h0000, full: 5'b00000, exp_en: 5'b00001};
        vecs[4] = '{vld: 1'b1, data: 16'hFFFF, full: 5'b01000, exp_en: 5'b00001};

        sys_rst_n    = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        bank_full    = '0;
        rd_bank_gray = 3'b000;
        ovf_clr      = 1'b0;
        #12;
        chk("rst_en",       32'(bank_wr_en), 32'h0);
        chk("rst_wr_bank",  32'(wr_bank),    32'h0);
        chk("rst_overflow", 32'(overflow),   32'h0);
        chk("rst_drop",     32'(drop_cnt),   32'h0);
        chk("rst_wrap",     32'(wrap_cnt),   32'h0);
        tick();
        sys_rst_n = 1'b1;
        tick();

        // FILL on bank 0: write enable and data follow inputs in the same cycle
        for (int i = 0; i < 5; i++) begin
            in_valid  = vecs[i].vld;
            in_data   = vecs[i].data;
            bank_full = vecs[i].full;
            #1;
            chk($sformatf("vec%0d_en", i),   32'(bank_wr_en),   32'(vecs[i].exp_en));
            chk($sformatf("vec%0d_data", i), 32'(bank_wr_data), 32'(vecs[i].data));
            tick();
            chk($sformatf("vec%0d_bank", i), 32'(wr_bank),  32'h0);
            chk($sformatf("vec%0d_drop", i), 32'(drop_cnt), 32'(exp_drop));
        end

        // Bank 0 full, reader on bank 3: one ADVANCE cycle, its sample dropped
        in_valid     = 1'b0;
        bank_full    = '0;
        rd_bank_gray = 3'b010;
        ticks(3);
        bank_full = 5'b00001;
        #1;
        chk("a_fill_full_en", 32'(bank_wr_en), 32'h0);
        tick();
        in_valid = 1'b1;
        in_data  = 16'h2222;
        #1;
        chk("a_adv_en", 32'(bank_wr_en), 32'h0);
        tick();
        exp_drop++;
        chk("a_bank", 32'(wr_bank),  32'h1);
        chk("a_drop", 32'(drop_cnt), 32'(exp_drop));
        chk("a_ovf",  32'(overflow), 32'h1);
        bank_full = '0;
        in_data   = 16'h3333;
        #1;
        chk("a_en_bank1", 32'(bank_wr_en),   32'h02);
        chk("a_data",     32'(bank_wr_data), 32'h3333);
        tick();
        chk("a_drop_stable", 32'(drop_cnt), 32'(exp_drop));

        // Reach bank 2, then hold because bank 3 is being read
        in_valid = 1'b0;
        leave_bank(1);
        chk("b_bank2", 32'(wr_bank), 32'h2);
        bank_full = 5'b00100;
        ticks(2);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("b_hold_en%0d", i), 32'(bank_wr_en), 32'h0);
            tick();
            exp_drop++;
        end
        chk("b_hold_bank", 32'(wr_bank),    32'h2);
        chk("b_drop",      32'(drop_cnt),   32'(exp_drop));
        chk("b_ovf",       32'(overflow),   32'h1);
        chk("b_drop_sat4", 32'(s_drop_cnt), 32'(exp_drop));
        in_valid     = 1'b0;
        rd_bank_gray = 3'b110;
        for (int i = 0; i < 4 && wr_bank != 3'd3; i++) tick();
        chk("b_release_bank", 32'(wr_bank), 32'h3);
        bank_full = '0;

        // Bank 3 -> 4 -> 0 with the reader on bank 2: one wrap
        rd_bank_gray = 3'b011;
        ticks(3);
        leave_bank(3);
        chk("c_bank4", 32'(wr_bank),  32'h4);
        chk("c_nowrap", 32'(wrap_cnt), 32'h0);
        leave_bank(4);
        chk("c_bank0", 32'(wr_bank),  32'h0);
        chk("c_wrap",  32'(wrap_cnt), 32'h1);

        // Drop storm while holding on bank 0 (reader on bank 1)
        rd_bank_gray = 3'b001;
        ticks(3);
        bank_full = 5'b00001;
        in_valid  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_drop++;
        end
        chk("d_hold_bank", 32'(wr_bank),    32'h0);
        chk("d_drop",      32'(drop_cnt),   32'(exp_drop));
        chk("d_drop_sat",  32'(s_drop_cnt), 32'hF);
        ovf_clr = 1'b1;
        tick();
        exp_drop++;
        chk("d_clr_with_drop", 32'(overflow), 32'h1);
        in_valid = 1'b0;
        tick();
        chk("d_clr_alone", 32'(overflow),   32'h0);
        chk("d_drop_kept", 32'(drop_cnt),   32'(exp_drop));
        chk("d_sat_kept",  32'(s_drop_cnt), 32'hF);
        ovf_clr = 1'b0;

        // Walk to bank 3 and hold there with the reader on bank 4
        rd_bank_gray = 3'b000;
        ticks(3);
        bank_full = '0;
        chk("e_bank1", 32'(wr_bank), 32'h1);
        leave_bank(1);
        leave_bank(2);
        rd_bank_gray = 3'b110;
        ticks(3);
        bank_full = 5'b01000;
        ticks(4);
        chk("e_hold_bank3", 32'(wr_bank),  32'h3);
        chk("e_wrap_kept",  32'(wrap_cnt), 32'h1);

        // Asynchronous reset mid-cycle
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("e_rst_bank", 32'(wr_bank),    32'h0);
        chk("e_rst_ovf",  32'(overflow),   32'h0);
        chk("e_rst_drop", 32'(drop_cnt),   32'h0);
        chk("e_rst_wrap", 32'(wrap_cnt),   32'h0);
        chk("e_rst_en",   32'(bank_wr_en), 32'h0);
        bank_full    = '0;
        rd_bank_gray = 3'b000;
        tick();
        sys_rst_n = 1'b1;
        exp_drop  = 0;
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        #1;
        chk("e_post_en",   32'(bank_wr_en),   32'h01);
        chk("e_post_data", 32'(bank_wr_data), 32'hBEEF);
        tick();
        chk("e_post_drop", 32'(drop_cnt), 32'(exp_drop));
        in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
